seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between up to NUM_SRC requesters, e.g. the CPU register view, PC, ALU result and fault code.
- Each requester supplies a 16-bit hex word. The arbiter grants one requester at a time, in round-robin order.
- A granted owner keeps the display for at least HOLD_CYCLES so the digits stay readable.
- disp_data drives the 16-bit data input of the seven-segment decoder; disp_blank lets top level force all anodes off.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 800_000, minimum ownership time in clock cycles; 16 ms, one full 4-digit refresh at 50 MHz; must be >= 1.
- CNT_W, 20, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.
- IDLE_VALUE, 16'h0000, value driven on disp_data when there is no owner.

Ports:
- clock, input, 1, system clock (50 MHz on board).
- reset_n, input, 1, asynchronous active-low reset.
- req, input, NUM_SRC, level request per source; bit i = source i.
- data_in, input, 16*NUM_SRC, source i word on bits [16*i+15:16*i].
- grant, output, NUM_SRC, one-hot current owner, or all-zero; registered.
- disp_data, output, 16, word for the decoder; registered.
- disp_blank, output, 1, 1 = no owner, display off; registered.
- switch_pulse, output, 1, one-cycle pulse on the cycle a new grant first appears; registered.

Behaviour:
- Clock and reset
  - All state updates on posedge clock; reset_n low clears asynchronously.
  - Reset values: state IDLE, grant 0, disp_data IDLE_VALUE, disp_blank 1, switch_pulse 0, hold counter 0, last_owner NUM_SRC-1 (so source 0 wins first).
  - Reset mid-hold: outputs return to reset values immediately. The first grant after reset again starts the search at source 0.
- Round-robin pick
  - Winner = first set req bit, searching last_owner+1, last_owner+2, … modulo NUM_SRC.
  - last_owner itself is searched last.
  - last_owner updates on every grant.
- State IDLE
  - grant=0, disp_blank=1, disp_data=IDLE_VALUE.
  - If req != 0 at edge t: at edge t the state moves to HOLD; grant, disp_data (winner's data_in) and switch_pulse=1 appear after edge t; counter=0.
  - Latency req→grant: 1 cycle.
- State HOLD
  - Counter increments every cycle.
  - disp_data <= owner's data_in every cycle (1-cycle latency, tracks live value).
  - Owner dropping req has no effect; ownership is guaranteed for the full hold.
  - Transition to OPEN on the edge where counter == HOLD_CYCLES-1. Ownership in HOLD is therefore exactly HOLD_CYCLES cycles.
- State OPEN
  - disp_data keeps tracking the owner. Evaluated each edge:
  - Any req bit set other than owner's: re-arbitrate using round-robin. The new owner always differs from the current one in this case. grant, disp_data and last_owner update; switch_pulse=1; counter=0; go to HOLD.
  - Else, owner req still set: stay in OPEN. A sole requester keeps the display indefinitely.
  - Else (req==0): go to IDLE; grant=0, disp_blank=1, disp_data=IDLE_VALUE on that edge.
- Timing rules
  - switch_pulse is high only on the first cycle of each new grant. It is never high in IDLE.
  - grant is always one-hot or zero.
  - disp_blank == (grant == 0).
  - req changing in the same cycle as the hold expiry is sampled at the HOLD→OPEN edge. Re-arbitration uses req sampled in OPEN, so hold expiry to new owner takes 2 cycles from the final HOLD cycle.
- Counter must not wrap: it is compared against HOLD_CYCLES-1 and cleared on every grant.

Test Plan (HOLD_CYCLES=4, NUM_SRC=4, source i data = 16'h1111*(i+1)):
- Reset, req=0 → grant=0, disp_blank=1, disp_data=16'h0000, switch_pulse=0; assert reset_n low mid-run → same values immediately, without waiting for a clock edge.
- req=4'b0100 from IDLE → after 1 edge grant=4'b0100, disp_data=16'h3333, switch_pulse high 1 cycle; keep req → grant held indefinitely.
- req=4'b1111 held → grants cycle 0001→0010→0100→1000→0001; each owner held 4 HOLD cycles + 1 OPEN cycle; switch_pulse once per change.
- Owner 0 drops req on cycle 2 of hold while req[2]=1 → grant stays 0001 until hold expires, then 0100.
- Sole owner source 1, change data_in[31:16] to 16'hBEEF → disp_data=16'hBEEF one cycle later; drop req in OPEN → next edge grant=0, disp_blank=1, disp_data=16'h0000.
- Owner source 3, req=4'b1001 at expiry → next owner source 0, because the search wraps from last_owner+1.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display between
// NUM_SRC requesters. Each owner is guaranteed HOLD_CYCLES of display time.
module seg_display_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          HOLD_CYCLES = 800_000,
    parameter int          CNT_W       = 20,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [16*NUM_SRC-1:0]  data_in,
    output logic [NUM_SRC-1:0]     grant,
    output logic [15:0]            disp_data,
    output logic                   disp_blank,
    output logic                   switch_pulse
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_SRC-1:0] grant_d;
    logic [15:0]        data_d;
    logic               blank_d, pulse_d;
    logic [NUM_SRC-1:0] other_req;
    logic [IDX_W-1:0]   pick_any, pick_other;

    // First set bit searching last+1, last+2, ... with last itself searched last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [15:0] word_of(input logic [IDX_W-1:0] idx,
                                            input logic [16*NUM_SRC-1:0] words);
        return words[16*int'(idx) +: 16];
    endfunction

    // While granted, last_q is also the current owner's index.
    assign other_req  = req & ~(ONE_HOT0 << last_q);
    assign pick_any   = rr_pick(req, last_q);
    assign pick_other = rr_pick(other_req, last_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant;
        data_d  = word_of(last_q, data_in);
        blank_d = disp_blank;
        pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                data_d  = IDLE_VALUE;
                blank_d = 1'b1;
                cnt_d   = '0;
                if (|req) begin
                    state_d = HOLD;
                    last_d  = pick_any;
                    grant_d = ONE_HOT0 << pick_any;
                    data_d  = word_of(pick_any, data_in);
                    blank_d = 1'b0;
                    pulse_d = 1'b1;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) state_d = OPEN;
            end
            OPEN: begin
                if (|other_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    last_d  = pick_other;
                    grant_d = ONE_HOT0 << pick_other;
                    data_d  = word_of(pick_other, data_in);
                    pulse_d = 1'b1;
                end else if (!req[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    data_d  = IDLE_VALUE;
                    blank_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to the top index so source 0 is searched first after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= IDX_W'(NUM_SRC - 1);
            grant        <= '0;
            disp_data    <= IDLE_VALUE;
            disp_blank   <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            grant        <= grant_d;
            disp_data    <= data_d;
            disp_blank   <= blank_d;
            switch_pulse <= pulse_d;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_SRC=4, HOLD_CYCLES=4 and
// source i word = 16'h1111*(i+1); outputs sampled on the falling clock edge.
module tb_seg_display_arbiter;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [63:0] data_in;
    logic [3:0]  grant;
    logic [15:0] disp_data;
    logic        disp_blank;
    logic        switch_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_arbiter #(
        .NUM_SRC    (4),
        .HOLD_CYCLES(4),
        .CNT_W      (3),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .data_in     (data_in),
        .grant       (grant),
        .disp_data   (disp_data),
        .disp_blank  (disp_blank),
        .switch_pulse(switch_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [15:0] d, input logic p);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_data"},  32'(disp_data), 32'(d));
        check({tag, "_blank"}, 32'(disp_blank), 32'(g == 4'b0000));
        check({tag, "_pulse"}, 32'(switch_pulse), 32'(p));
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [15:0] word(input int i);
        return 16'(16'h1111 * (i + 1));
    endfunction

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        data_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        @(negedge clock);
        expect_out("reset", 4'b0000, 16'h0000, 1'b0);
        reset_n = 1'b1;
        step();
        expect_out("idle", 4'b0000, 16'h0000, 1'b0);

        // Single requester from IDLE: 1-cycle latency, then kept indefinitely.
        req = 4'b0100;
        step();
        expect_out("sole2_first", 4'b0100, 16'h3333, 1'b1);
        for (int c = 0; c < 9; c++) step();
        expect_out("sole2_held", 4'b0100, 16'h3333, 1'b0);

        // Asynchronous reset between clock edges clears outputs at once.
        #2;
        reset_n = 1'b0;
        req     = 4'b0000;
        #1;
        expect_out("async_reset", 4'b0000, 16'h0000, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // All request: rotation restarts at source 0; 4 HOLD + 1 OPEN cycle each.
        req = 4'b1111;
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int o = 0; o < 5; o++) begin
                for (int c = 0; c < 5; c++) begin
                    step();
                    expect_out($sformatf("rr_o%0d_c%0d", o, c),
                               4'(4'b0001 << order[o]), word(order[o]), c == 0);
                end
            end
        end
        req = 4'b0000;
        step();
        expect_out("rr_to_idle", 4'b0000, 16'h0000, 1'b0);

        // Owner 0 drops its request mid-hold; ownership still runs the full hold.
        req = 4'b0001;
        step();
        expect_out("drop_c1", 4'b0001, 16'h1111, 1'b1);
        req = 4'b0100;
        for (int c = 2; c <= 5; c++) begin
            step();
            expect_out($sformatf("drop_c%0d", c), 4'b0001, 16'h1111, 1'b0);
        end
        step();
        expect_out("drop_next", 4'b0100, 16'h3333, 1'b1);

        // Hand over to source 1, then track a live data change.
        req = 4'b0010;
        for (int c = 2; c <= 5; c++) step();
        expect_out("to1_open2", 4'b0100, 16'h3333, 1'b0);
        step();
        expect_out("to1_first", 4'b0010, 16'h2222, 1'b1);
        data_in[31:16] = 16'hBEEF;
        step();
        expect_out("beef", 4'b0010, 16'hBEEF, 1'b0);
        for (int c = 0; c < 4; c++) step();
        expect_out("sole1_open", 4'b0010, 16'hBEEF, 1'b0);
        req = 4'b0000;
        step();
        expect_out("open_to_idle", 4'b0000, 16'h0000, 1'b0);
        step();
        expect_out("idle_stays", 4'b0000, 16'h0000, 1'b0);

        // Owner 3 with req 1001 at expiry: search wraps to source 0.
        data_in[31:16] = 16'h2222;
        req = 4'b1000;
        step();
        expect_out("own3_first", 4'b1000, 16'h4444, 1'b1);
        for (int c = 2; c <= 4; c++) step();
        req = 4'b1001;
        step();
        expect_out("own3_open", 4'b1000, 16'h4444, 1'b0);
        step();
        expect_out("wrap_to0", 4'b0001, 16'h1111, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
